// File: rtl/tile_cycler_pkg.sv
// -----------------------------------------------------------------------------
// tile_cycler_pkg
//   Shared definitions for the multi-tile colour cycler: colour index width,
//   the per-button step FSM states and the RGB565 palette with its lookup.
// -----------------------------------------------------------------------------
package tile_cycler_pkg;

  localparam int IDX_W = 3;

  localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB_BLUE   = 16'h001F;
  localparam logic [15:0] RGB_ORANGE = 16'hFD20;
  localparam logic [15:0] RGB_BLACK  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    WAIT_REL
  } step_state_t;

  // Indices outside the six-entry palette paint black.
  function automatic logic [15:0] palette_rgb(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    palette_rgb = RGB_WHITE;
      3'd1:    palette_rgb = RGB_RED;
      3'd2:    palette_rgb = RGB_GREEN;
      3'd3:    palette_rgb = RGB_BLUE;
      3'd4:    palette_rgb = RGB_ORANGE;
      default: palette_rgb = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/press_stepper.sv
// -----------------------------------------------------------------------------
// press_stepper
//   One button channel: 2-FF synchroniser, rising-edge detector, lockout FSM
//   and the colour index it steps.
//   Ports:
//     CLK     system clock
//     RESETN  asynchronous active-low reset
//     en      accept new presses when high
//     tick    one-CLK debounce tick strobe
//     btn     raw pushbutton
//     idx     current colour index (0..NUM_COLOURS-1)
// -----------------------------------------------------------------------------
module press_stepper
  import tile_cycler_pkg::*;
#(
  parameter int NUM_COLOURS = 6,
  parameter int LOCK_TICKS  = 200
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             en,
  input  logic             tick,
  input  logic             btn,
  output logic [IDX_W-1:0] idx
);

  localparam int LCW = $clog2(LOCK_TICKS + 1);

  logic             sync1, sync2, prev;
  logic             rise;
  step_state_t      state, state_nxt;
  logic [LCW-1:0]   lock_cnt, lock_cnt_nxt;
  logic [IDX_W-1:0] idx_nxt;

  // Edge detector runs every cycle, independent of en, so a button held
  // while en rises never produces a late rise.
  assign rise = sync2 & ~prev;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's pre-edge value;
      // blocking assignments here would collapse the chain into one stage.
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      lock_cnt <= '0;
      idx      <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      idx      <= idx_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    idx_nxt      = idx;
    case (state)
      IDLE: begin
        if (rise && en) begin
          idx_nxt      = (idx == IDX_W'(NUM_COLOURS - 1)) ? '0 : idx + 1'b1;
          lock_cnt_nxt = '0;
          state_nxt    = LOCK;
        end
      end
      LOCK: begin
        if (tick) begin
          lock_cnt_nxt = lock_cnt + 1'b1;
          // This tick is the LOCK_TICKS-th since the press was accepted.
          if (lock_cnt == LCW'(LOCK_TICKS - 1))
            state_nxt = sync2 ? WAIT_REL : IDLE;
        end
      end
      WAIT_REL: begin
        if (tick && !sync2)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/multi_tile_colour_cycler.sv
// -----------------------------------------------------------------------------
// multi_tile_colour_cycler
//   NUM_TILES debounced pushbuttons each step a palette index; the indices are
//   painted as a vertical stack of tiles plus a "match" disc into the OLED
//   pixel stream. RESETN is expected to be release-synchronised to CLK
//   upstream; assertion takes effect immediately.
//   Ports:
//     CLK         system clock
//     RESETN      asynchronous active-low reset
//     en          accept new presses when high
//     btn         raw pushbuttons, bit k drives tile k
//     pix_tick    one-CLK pixel strobe
//     x, y        current pixel column (0..95) / row (0..63)
//     colour_idx  index per tile, tile k at [3k+2:3k]
//     oled_data   registered RGB565 pixel, updated on pix_tick
// -----------------------------------------------------------------------------
module multi_tile_colour_cycler
  import tile_cycler_pkg::*;
#(
  parameter int         NUM_TILES   = 3,
  parameter int         NUM_COLOURS = 6,
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         TICK_HZ     = 1000,
  parameter int         LOCK_TICKS  = 200,
  parameter int         TILE_X0     = 42,
  parameter int         TILE_Y0     = 3,
  parameter int         TILE_W      = 14,
  parameter int         TILE_H      = 14,
  parameter int         TILE_PITCH  = 16,
  parameter int         IND_CX      = 48,
  parameter int         IND_CY      = 56,
  parameter int         IND_R2      = 42,
  parameter logic [5:0] MATCH_MASK  = 6'b010010
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic                       en,
  input  logic [NUM_TILES-1:0]       btn,
  input  logic                       pix_tick,
  input  logic [6:0]                 x,
  input  logic [5:0]                 y,
  output logic [IDX_W*NUM_TILES-1:0] colour_idx,
  output logic [15:0]                oled_data
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TCW = (DIV > 1) ? $clog2(DIV) : 1;

  // ---------------- tick generator ----------------
  logic [TCW-1:0] tick_cnt;
  logic           tick;

  assign tick = (tick_cnt == TCW'(DIV - 1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) tick_cnt <= '0;
    else         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // ---------------- button channels ----------------
  for (genvar k = 0; k < NUM_TILES; k++) begin : g_chan
    press_stepper #(
      .NUM_COLOURS(NUM_COLOURS),
      .LOCK_TICKS (LOCK_TICKS)
    ) u_step (
      .CLK   (CLK),
      .RESETN(RESETN),
      .en    (en),
      .tick  (tick),
      .btn   (btn[k]),
      .idx   (colour_idx[IDX_W*k +: IDX_W])
    );
  end

  // ---------------- match indicator ----------------
  logic [IDX_W-1:0] idx0;
  logic             all_same;
  logic [7:0]       mask8;
  logic             ind_lit;

  assign idx0  = colour_idx[IDX_W-1:0];
  assign mask8 = {2'b00, MATCH_MASK};

  always_comb begin
    all_same = 1'b1;
    for (int k = 1; k < NUM_TILES; k++)
      if (colour_idx[IDX_W*k +: IDX_W] != idx0) all_same = 1'b0;
  end

  assign ind_lit = all_same && mask8[idx0];

  // Distances are 8-bit signed; squaring after sign extension to 16 bits keeps
  // the magnitude, so points left of / above the centre do not wrap.
  logic signed [7:0]  dx, dy;
  logic signed [15:0] dx_w, dy_w;
  logic [15:0]        dx_sq, dy_sq;
  logic [16:0]        dist2;
  logic               in_disc;

  assign dx      = 8'({1'b0, x}) - 8'(IND_CX);
  assign dy      = 8'({2'b00, y}) - 8'(IND_CY);
  assign dx_w    = {{8{dx[7]}}, dx};
  assign dy_w    = {{8{dy[7]}}, dy};
  assign dx_sq   = dx_w * dx_w;
  assign dy_sq   = dy_w * dy_w;
  assign dist2   = {1'b0, dx_sq} + {1'b0, dy_sq};
  assign in_disc = (dist2 <= 17'(IND_R2));

  // ---------------- pixel painter ----------------
  int                   xi, yi;
  logic [NUM_TILES-1:0] in_tile;
  logic [15:0]          pixel_nxt;

  assign xi = int'(x);
  assign yi = int'(y);

  always_comb begin
    for (int k = 0; k < NUM_TILES; k++)
      in_tile[k] = (xi >= TILE_X0) && (xi <= TILE_X0 + TILE_W - 1) &&
                   (yi >= TILE_Y0 + k*TILE_PITCH) &&
                   (yi <= TILE_Y0 + k*TILE_PITCH + TILE_H - 1);
  end

  // Walk tiles from the highest number down so the lowest-numbered hit wins,
  // and any tile overrides the disc.
  always_comb begin
    pixel_nxt = (ind_lit && in_disc) ? palette_rgb(idx0) : RGB_BLACK;
    for (int k = NUM_TILES - 1; k >= 0; k--)
      if (in_tile[k]) pixel_nxt = palette_rgb(colour_idx[IDX_W*k +: IDX_W]);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)       oled_data <= RGB_BLACK;
    else if (pix_tick) oled_data <= pixel_nxt;
  end

endmodule

// File: tb/tb_multi_tile_colour_cycler.sv
module tb_multi_tile_colour_cycler;

  localparam int NT         = 3;
  localparam int NC         = 6;
  localparam int CLK_HZ     = 1000;
  localparam int TICK_HZ    = 100;
  localparam int DIV        = CLK_HZ / TICK_HZ;
  localparam int LOCK_TICKS = 3;
  localparam logic [5:0] MASK = 6'b010010;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            pix_tick = 1'b0;
  logic [NT-1:0]   btn = '0;
  logic [6:0]      x = '0;
  logic [5:0]      y = '0;
  logic [3*NT-1:0] colour_idx;
  logic [15:0]     oled_data;

  multi_tile_colour_cycler #(
    .NUM_TILES  (NT),
    .NUM_COLOURS(NC),
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .LOCK_TICKS (LOCK_TICKS)
  ) dut (
    .CLK       (clk),
    .RESETN    (rst_n),
    .en        (en),
    .btn       (btn),
    .pix_tick  (pix_tick),
    .x         (x),
    .y         (y),
    .colour_idx(colour_idx),
    .oled_data (oled_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Each channel is either ready for a press, counting down its lock ticks,
  // or (ticks exhausted, not ready) waiting for a tick that sees it released.
  int            m_idx[NT];
  int            m_ticks_left[NT];
  bit            m_ready[NT];
  logic [NT-1:0] h1, h2, h3;   // btn as sampled 1, 2, 3 edges ago
  int            m_edges;
  logic [15:0]   m_oled;

  function automatic logic [15:0] pal(input int i);
    case (i)
      0: return 16'hFFFF;
      1: return 16'hF800;
      2: return 16'h07E0;
      3: return 16'h001F;
      4: return 16'hFD20;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] paint(input int px, input int py);
    bit same;
    for (int k = 0; k < NT; k++)
      if (px >= 42 && px <= 55 && py >= 3 + 16*k && py <= 16 + 16*k) return pal(m_idx[k]);
    same = 1'b1;
    for (int k = 1; k < NT; k++) if (m_idx[k] != m_idx[0]) same = 1'b0;
    if (same && MASK[m_idx[0]] && ((px-48)*(px-48) + (py-56)*(py-56) <= 42))
      return pal(m_idx[0]);
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_idx[k] = 0; m_ticks_left[k] = 0; m_ready[k] = 1'b1;
    end
    h1 = '0; h2 = '0; h3 = '0;
    m_edges = 0;
    m_oled = 16'h0000;
  endtask

  task automatic model_step();
    bit tick_now;
    tick_now = (m_edges % DIV) == DIV - 1;
    m_edges++;
    if (pix_tick) m_oled = paint(int'(x), int'(y));
    for (int k = 0; k < NT; k++) begin
      bit s, r;
      s = h2[k];
      r = h2[k] && !h3[k];
      if (m_ready[k]) begin
        if (r && en) begin
          m_idx[k] = (m_idx[k] + 1) % NC;
          m_ready[k] = 1'b0;
          m_ticks_left[k] = LOCK_TICKS;
        end
      end else if (m_ticks_left[k] > 0) begin
        if (tick_now) begin
          m_ticks_left[k]--;
          if (m_ticks_left[k] == 0) m_ready[k] = !s;
        end
      end else if (tick_now && !s) begin
        m_ready[k] = 1'b1;
      end
    end
    h3 = h2; h2 = h1; h1 = btn;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare on every falling edge, well away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < NT; k++)
      check($sformatf("model_idx%0d", k), 32'(colour_idx[3*k +: 3]), 32'(m_idx[k]));
    check("model_oled", 32'(oled_data), 32'(m_oled));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [NT-1:0] mask, input int hold, input int gap);
    btn = btn | mask;
    cycles(hold);
    btn = btn & ~mask;
    cycles(gap);
  endtask

  task automatic set_indices(input int t0, input int t1, input int t2);
    int tgt[NT];
    logic [NT-1:0] m;
    tgt = '{t0, t1, t2};
    for (int r = 0; r < 2*NC; r++) begin
      m = '0;
      for (int k = 0; k < NT; k++) if (m_idx[k] != tgt[k]) m[k] = 1'b1;
      if (m != '0) press(m, 5, 45);
    end
    check("set_indices", 32'(colour_idx), 32'({3'(t2), 3'(t1), 3'(t0)}));
  endtask

  task automatic pixel(input int px, input int py);
    x = 7'(px);
    y = 6'(py);
    pix_tick = 1'b1;
    cycles(1);
    pix_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int SEQ[6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    rst_n = 1'b0; en = 1'b1;
    cycles(3);
    check("reset_idx", 32'(colour_idx), 32'd0);
    check("reset_oled", 32'(oled_data), 32'd0);
    rst_n = 1'b1;
    cycles(5);

    // Single pulse on btn[0]: increments 3 CLK after the raw edge, once.
    btn[0] = 1'b1;
    cycles(2);
    check("t0_before_latency", 32'(colour_idx[2:0]), 32'd0);
    cycles(1);
    check("t0_at_latency", 32'(colour_idx[2:0]), 32'd1);
    cycles(47);
    btn[0] = 1'b0;
    cycles(60);
    check("t0_single", 32'(colour_idx), 32'h001);

    // Long hold on btn[1] counts once; release, 10 CLK, press again.
    btn[1] = 1'b1;
    cycles(500);
    check("t1_held", 32'(colour_idx[5:3]), 32'd1);
    btn[1] = 1'b0;
    cycles(10);
    press(3'b010, 5, 40);
    check("t1_repress", 32'(colour_idx[5:3]), 32'd2);

    // Press inside the lock window is ignored; one 60 CLK later counts.
    press(3'b001, 5, 10);
    check("t0_accept", 32'(colour_idx[2:0]), 32'd2);
    press(3'b001, 5, 10);
    check("t0_lock_ignored", 32'(colour_idx[2:0]), 32'd2);
    cycles(45);
    press(3'b001, 5, 30);
    check("t0_after_lock", 32'(colour_idx[2:0]), 32'd3);

    // Six presses on btn[2] walk the palette and wrap.
    for (int i = 0; i < 6; i++) begin
      press(3'b100, 5, 45);
      check($sformatf("t2_seq%0d", i), 32'(colour_idx[8:6]), 32'(SEQ[i]));
    end

    // Pixel path.
    set_indices(1, 1, 1);
    pixel(48, 56);
    check("pix_disc_red", 32'(oled_data), 32'hF800);
    x = '0; y = '0;
    cycles(3);
    check("pix_hold", 32'(oled_data), 32'hF800);
    set_indices(3, 1, 1);
    pixel(48, 10);
    check("pix_tile0_blue", 32'(oled_data), 32'h001F);
    pixel(48, 56);
    check("pix_disc_nomatch", 32'(oled_data), 32'h0000);
    pixel(55, 16);
    check("pix_tile0_corner", 32'(oled_data), 32'h001F);
    pixel(56, 16);
    check("pix_right_of_tile", 32'(oled_data), 32'h0000);
    pixel(42, 17);
    check("pix_tile_gap", 32'(oled_data), 32'h0000);
    pixel(42, 19);
    check("pix_tile1_top", 32'(oled_data), 32'hF800);
    set_indices(2, 2, 2);
    pixel(48, 56);
    check("pix_disc_unmasked", 32'(oled_data), 32'h0000);
    set_indices(4, 4, 4);
    pixel(48, 56);
    check("pix_disc_orange", 32'(oled_data), 32'hFD20);
    pixel(54, 57);
    check("pix_disc_edge_in", 32'(oled_data), 32'hFD20);
    pixel(55, 56);
    check("pix_disc_edge_out", 32'(oled_data), 32'h0000);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < NT; k++)
        if ($urandom_range(0, 29) == 0) btn[k] = ~btn[k];
      pix_tick = ($urandom_range(0, 2) == 0);
      x = 7'($urandom_range(36, 62));
      y = 6'($urandom_range(0, 63));
      cycles(1);
    end
    btn = '0; en = 1'b1; pix_tick = 1'b0;
    cycles(60);

    // en low: presses ignored; a button held across en rising does not count.
    set_indices(0, 0, 0);
    en = 1'b0;
    btn[0] = 1'b1;
    cycles(20);
    check("en_off_press", 32'(colour_idx[2:0]), 32'd0);
    en = 1'b1;
    cycles(20);
    check("en_rise_held", 32'(colour_idx[2:0]), 32'd0);
    btn[0] = 1'b0;
    cycles(40);
    press(3'b001, 5, 40);
    check("en_on_press", 32'(colour_idx[2:0]), 32'd1);

    // Asynchronous reset in the middle of LOCK.
    btn[0] = 1'b1;
    cycles(4);
    pixel(48, 10);
    check("pre_reset_oled", 32'(oled_data), 32'h07E0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_idx", 32'(colour_idx), 32'd0);
    check("async_reset_oled", 32'(oled_data), 32'd0);
    @(negedge clk);
    btn[0] = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
    btn[0] = 1'b1;
    cycles(3);
    check("post_reset_idle", 32'(colour_idx[2:0]), 32'd1);
    btn[0] = 1'b0;
    cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
